// File: rtl/st2_bist_ctrl.sv
// BIST controller for the Stage 2 four-input sequential CUT.
// Flushes the CUT with a fixed vector, then drives LFSR patterns onto A..D
// and compacts the Y response into an 8-bit MISR signature.
module st2_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 255,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter logic [3:0]  FLUSH_VEC    = 4'b0000,
  parameter logic [7:0]  SEED         = 8'h01,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cut_y,
  output logic       cut_a,
  output logic       cut_b,
  output logic       cut_c,
  output logic       cut_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] pat_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_PAT   = 8'(NUM_PATTERNS - 1);
  localparam logic [3:0] LAST_FLUSH = 4'(FLUSH_CYCLES - 1);

  state_t     state_q;
  logic [7:0] lfsr_q;
  logic [7:0] misr_q;
  logic [7:0] pat_cnt_q;
  logic [3:0] flush_cnt_q;
  logic [3:0] cut_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic [7:0] lfsr_d;
  logic [7:0] misr_d;

  // Next LFSR and MISR values (x^8+x^6+x^5+x^4+1), MISR folding in Y
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign misr_d = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3] ^ cut_y};

  // Control FSM with all CUT drives and status flags registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      misr_q      <= 8'h00;
      pat_cnt_q   <= 8'h00;
      flush_cnt_q <= 4'h0;
      cut_q       <= FLUSH_VEC;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      cut_q   <= FLUSH_VEC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= FLUSH;
            lfsr_q      <= SEED;
            misr_q      <= 8'h00;
            pat_cnt_q   <= 8'h00;
            flush_cnt_q <= 4'h0;
            cut_q       <= FLUSH_VEC;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + 4'd1;
          if (flush_cnt_q == LAST_FLUSH) begin
            cut_q   <= lfsr_q[3:0];
            lfsr_q  <= lfsr_d;
            state_q <= RUN;
          end
        end
        RUN: begin
          misr_q    <= misr_d;
          pat_cnt_q <= pat_cnt_q + 8'd1;
          if (pat_cnt_q == LAST_PAT) begin
            state_q <= DONE;
            cut_q   <= FLUSH_VEC;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (misr_d == GOLDEN_SIG);
          end else begin
            cut_q  <= lfsr_q[3:0];
            lfsr_q <= lfsr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cut_q   <= FLUSH_VEC;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cut_a     = cut_q[3];
  assign cut_b     = cut_q[2];
  assign cut_c     = cut_q[1];
  assign cut_d     = cut_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;
  assign pat_cnt   = pat_cnt_q;

endmodule
